// File: rtl/instruction_memory.sv
// rtl/instruction_memory.sv - combinational read-only instruction store holding the compare-loop demo program
module instruction_memory #(
  parameter int DEPTH      = 64,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           address,
  output logic [DATA_WIDTH-1:0] instruction
);

  // Opcode fields of the three instruction kinds used by the demo program
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  // Register numbers used by the program
  localparam logic [4:0] R_ZERO = 5'd0;
  localparam logic [4:0] R_T0   = 5'd8;
  localparam logic [4:0] R_S0   = 5'd16;
  localparam logic [4:0] R_S1   = 5'd17;

  // Byte address of the halt loop; every beq and the j target this word
  localparam logic [31:0] DONE_ADDR = 32'h0000_0038;

  // Upper bound of the populated word range, widened to the index width
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  // Word index from the PC; the low two byte-select bits play no part in the lookup
  logic [29:0] word_idx;
  assign word_idx = address[31:2];

  // The ROM is stateless, so the clock, reset and byte-select bits are deliberately left unconnected
  logic unused_inputs;
  assign unused_inputs = &{1'b0, clk, reset, address[1:0]};

  // I-type addi rt, rs, imm
  function automatic logic [31:0] enc_addi(input logic [4:0] rt, input logic [4:0] rs,
                                           input logic [15:0] imm);
    enc_addi = {OP_ADDI, rs, rt, imm};
  endfunction

  // beq $s0, $t0, done where the branch at byte address pc lands on the halt loop
  function automatic logic [31:0] enc_beq_done(input logic [31:0] pc);
    logic [31:0] delta;
    delta        = (DONE_ADDR - (pc + 32'd4)) >> 2;
    enc_beq_done = {OP_BEQ, R_S0, R_T0, delta[15:0]};
  endfunction

  // j done, jumping to the halt loop by word address
  function automatic logic [31:0] enc_j_done();
    logic [31:0] target;
    target     = DONE_ADDR >> 2;
    enc_j_done = {OP_J, target[25:0]};
  endfunction

  // Program lookup; anything outside the populated words or beyond DEPTH reads as NOP
  always_comb begin
    instruction = '0;
    if (word_idx < DEPTH_W) begin
      case (word_idx)
        30'd0:   instruction = enc_addi(R_S0, R_ZERO, 16'd4);
        30'd1:   instruction = enc_addi(R_T0, R_ZERO, 16'd1);
        30'd2:   instruction = enc_addi(R_S1, R_ZERO, 16'd0);
        30'd3:   instruction = enc_beq_done(32'h0000_000C);
        30'd4:   instruction = enc_addi(R_T0, R_ZERO, 16'd2);
        30'd5:   instruction = enc_addi(R_S1, R_ZERO, 16'd8);
        30'd6:   instruction = enc_beq_done(32'h0000_0018);
        30'd7:   instruction = enc_addi(R_T0, R_ZERO, 16'd3);
        30'd8:   instruction = enc_addi(R_S1, R_ZERO, 16'd15);
        30'd9:   instruction = enc_beq_done(32'h0000_0024);
        30'd10:  instruction = enc_addi(R_T0, R_ZERO, 16'd4);
        30'd11:  instruction = enc_addi(R_S1, R_ZERO, 16'd22);
        30'd12:  instruction = enc_beq_done(32'h0000_0030);
        30'd13:  instruction = enc_addi(R_S1, R_ZERO, 16'd28);
        30'd14:  instruction = enc_j_done();
        default: instruction = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_memory.sv
// tb/tb_instruction_memory.sv - directed self-checking bench for instruction_memory
module tb_instruction_memory;

  logic        clk;
  logic        reset;
  logic [31:0] address;
  logic [31:0] instruction;

  int checks;
  int passed;

  logic [31:0] expected_rom [15];

  instruction_memory #(.DEPTH(64), .DATA_WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .instruction (instruction)
  );

  task automatic check(input string tag, input logic [31:0] exp);
    checks++;
    assert (instruction === exp) passed++;
    else $error("FAIL %s: instruction=%h expected=%h", tag, instruction, exp);
  endtask

  initial begin
    checks = 0;
    passed = 0;
    expected_rom[0]  = 32'h2010_0004;
    expected_rom[1]  = 32'h2008_0001;
    expected_rom[2]  = 32'h2011_0000;
    expected_rom[3]  = 32'h1208_000A;
    expected_rom[4]  = 32'h2008_0002;
    expected_rom[5]  = 32'h2011_0008;
    expected_rom[6]  = 32'h1208_0007;
    expected_rom[7]  = 32'h2008_0003;
    expected_rom[8]  = 32'h2011_000F;
    expected_rom[9]  = 32'h1208_0004;
    expected_rom[10] = 32'h2008_0004;
    expected_rom[11] = 32'h2011_0016;
    expected_rom[12] = 32'h1208_0001;
    expected_rom[13] = 32'h2011_001C;
    expected_rom[14] = 32'h0800_000E;

    // clk and reset stay undriven (X) until the reset-toggle step
    address = 32'h0000_0024;
    #10;
    check("undriven_clk_reset_0x24", 32'h1208_0004);
    checks++;
    assert (!$isunknown(instruction)) passed++;
    else $error("FAIL no_x_0x24: instruction=%h expected=no X bits", instruction);

    // Word sweep across the whole program
    for (int i = 0; i < 15; i++) begin
      address = 32'(i * 4);
      #10;
      check($sformatf("sweep_0x%02h", i * 4), expected_rom[i]);
    end

    // Misaligned reads return the containing word
    address = 32'h0000_0001; #10; check("misaligned_0x01", 32'h2010_0004);
    address = 32'h0000_0002; #10; check("misaligned_0x02", 32'h2010_0004);
    address = 32'h0000_0003; #10; check("misaligned_0x03", 32'h2010_0004);
    address = 32'h0000_0037; #10; check("misaligned_0x37", 32'h2011_001C);

    // Unprogrammed, past-depth and top-of-space addresses read as NOP
    address = 32'h0000_003C; #10; check("unprogrammed_0x3C", 32'h0000_0000);
    address = 32'h0000_00FC; #10; check("last_word_0xFC", 32'h0000_0000);
    address = 32'h0000_0100; #10; check("past_depth_0x100", 32'h0000_0000);
    address = 32'hFFFF_FFFC; #10; check("no_wrap_0xFFFFFFFC", 32'h0000_0000);
    address = 32'h0000_0138; #10; check("no_alias_0x138", 32'h0000_0000);

    // Clocking with reset held high, then released, must not disturb the output
    address = 32'h0000_002C;
    clk     = 1'b0;
    reset   = 1'b1;
    #5;
    for (int c = 0; c < 3; c++) begin
      clk = 1'b1; #1;
      check($sformatf("reset_cycle%0d_post_edge", c), 32'h2011_0016);
      #4;
      clk = 1'b0; #5;
      check($sformatf("reset_cycle%0d_low", c), 32'h2011_0016);
    end
    reset = 1'b0;
    clk = 1'b1; #1;
    check("after_reset_release", 32'h2011_0016);
    #4;
    clk = 1'b0; #5;

    // Mid-cycle address change with clk held low
    address = 32'h0000_0010; #3; check("midcycle_0x10", 32'h2008_0002);
    address = 32'h0000_0014; #1; check("midcycle_0x14", 32'h2011_0008);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
